// File: rtl/braille_cell_driver.sv
// Refreshable braille cell driver: on each pattern change it releases all pins, pulses the
// raised pins one at a time, then holds. Define BRAILLE_HOLD_PWM_EN to enable PWM hold drive.
module braille_cell_driver #(
  parameter int unsigned RELEASE_CYCLES = 16,
  parameter int unsigned PULSE_CYCLES   = 32,
  parameter int unsigned HOLD_DUTY      = 4,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cell_in,
  input  logic       enable,
  output logic [7:0] dot_drive,
  output logic [7:0] cell_shown,
  output logic       busy,
  output logic       update_done
);

  typedef enum logic [1:0] {
    IDLE,
    RELEASE,
    PULSE,
    HOLD
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] RELEASE_END = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_END   = CNT_W'(PULSE_CYCLES - 1);

  generate
    if (RELEASE_CYCLES < 1 || PULSE_CYCLES < 1) begin : g_bad_cycles
      $error("RELEASE_CYCLES and PULSE_CYCLES must be at least 1");
    end
    if (HOLD_DUTY > 16) begin : g_bad_duty
      $error("HOLD_DUTY must be in 0..16");
    end
    if (CNT_W < 32 && (RELEASE_CYCLES > (32'd1 << CNT_W) || PULSE_CYCLES > (32'd1 << CNT_W)))
    begin : g_bad_cnt_w
      $error("CNT_W too narrow for RELEASE_CYCLES/PULSE_CYCLES");
    end
  endgenerate

  state_t           state, state_n;
  logic [2:0]       dot_idx, dot_idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       shown_n;
  logic [7:0]       drive_n;
  logic [7:0]       cur_bit;
  logic [7:0]       below_mask;
  logic             busy_n;
  logic             done_n;
  logic             chg;
  logic             hold_phase;

`ifdef BRAILLE_HOLD_PWM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + 4'd1;
  end

  assign hold_phase = ({1'b0, pwm_cnt} < 5'(HOLD_DUTY));
`else
  assign hold_phase = 1'b1;
`endif

  assign chg = enable && (cell_in != cell_shown);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      dot_idx     <= '0;
      cnt         <= '0;
      cell_shown  <= '0;
      dot_drive   <= '0;
      busy        <= 1'b0;
      update_done <= 1'b0;
    end else begin
      state       <= state_n;
      dot_idx     <= dot_idx_n;
      cnt         <= cnt_n;
      cell_shown  <= shown_n;
      dot_drive   <= drive_n;
      busy        <= busy_n;
      update_done <= done_n;
    end
  end

  // Outputs are registered, so they are decoded from the next-state values.
  always_comb begin
    state_n    = state;
    dot_idx_n  = dot_idx;
    cnt_n      = cnt;
    shown_n    = cell_shown;
    done_n     = 1'b0;
    drive_n    = '0;
    busy_n     = 1'b0;
    cur_bit    = '0;
    below_mask = '0;

    if (!enable) begin
      state_n   = IDLE;
      dot_idx_n = '0;
      cnt_n     = '0;
      shown_n   = '0;
    end else if (chg) begin
      state_n   = RELEASE;
      dot_idx_n = '0;
      cnt_n     = '0;
      shown_n   = cell_in;
    end else begin
      case (state)
        IDLE: ;
        RELEASE: begin
          if (cnt == RELEASE_END) begin
            state_n   = PULSE;
            dot_idx_n = '0;
            cnt_n     = '0;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        PULSE: begin
          // Lowered dots cost a single cycle; raised dots get the full pulse.
          if (!cell_shown[dot_idx] || cnt == PULSE_END) begin
            cnt_n = '0;
            if (dot_idx == 3'd7) begin
              state_n = HOLD;
              done_n  = 1'b1;
            end else begin
              dot_idx_n = dot_idx + 3'd1;
            end
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        HOLD: ;
        default: state_n = IDLE;
      endcase
    end

    cur_bit    = 8'd1 << dot_idx_n;
    below_mask = cur_bit - 8'd1;

    case (state_n)
      RELEASE: busy_n = 1'b1;
      PULSE: begin
        busy_n  = 1'b1;
        drive_n = (shown_n & below_mask & {8{hold_phase}}) | (shown_n & cur_bit);
      end
      HOLD:    drive_n = shown_n & {8{hold_phase}};
      default: drive_n = '0;
    endcase
  end

endmodule

// File: tb/tb_braille_cell_driver.sv
// Directed self-checking bench for braille_cell_driver (default timing parameters).
module tb_braille_cell_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cell_in;
  logic       enable;
  logic [7:0] dot_drive;
  logic [7:0] cell_shown;
  logic       busy;
  logic       update_done;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  // Main instance: HOLD_DUTY=16 keeps hold continuous whether or not PWM is built.
  braille_cell_driver #(
    .RELEASE_CYCLES(16),
    .PULSE_CYCLES  (32),
    .HOLD_DUTY     (16),
    .CNT_W         (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cell_in    (cell_in),
    .enable     (enable),
    .dot_drive  (dot_drive),
    .cell_shown (cell_shown),
    .busy       (busy),
    .update_done(update_done)
  );

`ifdef BRAILLE_HOLD_PWM_EN
  logic [7:0] dot_drive_p;
  logic [7:0] cell_shown_p;
  logic       busy_p;
  logic       update_done_p;

  braille_cell_driver #(
    .RELEASE_CYCLES(16),
    .PULSE_CYCLES  (32),
    .HOLD_DUTY     (4),
    .CNT_W         (16)
  ) dut_pwm (
    .clk        (clk),
    .reset      (reset),
    .cell_in    (cell_in),
    .enable     (enable),
    .dot_drive  (dot_drive_p),
    .cell_shown (cell_shown_p),
    .busy       (busy_p),
    .update_done(update_done_p)
  );
`endif

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ud(input int bound, output int lat);
    lat = 0;
    while (update_done !== 1'b1 && lat < bound) begin
      tick(1);
      lat++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int n_on;
    int n_off;
    logic [2:0] seen;

    // 1: reset and idle with a zero pattern
    reset   = 1'b1;
    cell_in = 8'h00;
    enable  = 1'b1;
    #3;
    chk("rst_drive", 16'(dot_drive), 16'h00);
    chk("rst_shown", 16'(cell_shown), 16'h00);
    chk("rst_busy_done", 16'({busy, update_done}), 16'h0);
    tick(2);
    #2 reset = 1'b0;
    tick(1);
    seen = '0;
    for (int i = 0; i < 100; i++) begin
      seen = seen | {update_done, busy, |dot_drive};
      tick(1);
    end
    chk("idle_quiet", 16'(seen), 16'h0);

    // 2: 0x17 refresh timeline, cycle 0 = capture edge
    cell_in = 8'h17;
    tick(1);
    chk("s2_c0_busy", 16'(busy), 16'h1);
    chk("s2_c0_shown", 16'(cell_shown), 16'h17);
    chk("s2_c0_drive", 16'(dot_drive), 16'h00);
    tick(15);
    chk("s2_c15_drive", 16'(dot_drive), 16'h00);
    tick(1);
    chk("s2_c16_drive", 16'(dot_drive), 16'h01);
    tick(32);
    chk("s2_c48_drive", 16'(dot_drive), 16'h03);
    tick(32);
    chk("s2_c80_drive", 16'(dot_drive), 16'h07);
    tick(32);
    chk("s2_c112_skip3", 16'(dot_drive), 16'h07);
    tick(1);
    chk("s2_c113_drive", 16'(dot_drive), 16'h17);
    tick(34);
    chk("s2_c147_busy_done", 16'({busy, update_done}), 16'h2);
    tick(1);
    chk("s2_c148_busy_done", 16'({busy, update_done}), 16'h1);
    chk("s2_c148_drive", 16'(dot_drive), 16'h17);
    tick(1);
    chk("s2_c149_done", 16'(update_done), 16'h0);
    chk("s2_hold_drive", 16'(dot_drive), 16'h17);
    chk("s2_hold_shown", 16'(cell_shown), 16'h17);

    // 3: 0xFF held; continuous on the main instance, 4/16 duty on the PWM instance
    cell_in = 8'hFF;
    tick(1);
    wait_ud(400, lat);
    chk("s3_latency", 16'(lat), 16'd272);
    n_on = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (dot_drive == 8'hFF) n_on++;
    end
    chk("s3_hold_steady", 16'(n_on), 16'd16);
`ifdef BRAILLE_HOLD_PWM_EN
    n_on  = 0;
    n_off = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (dot_drive_p == 8'hFF) n_on++;
      if (dot_drive_p == 8'h00) n_off++;
    end
    chk("s3_pwm_on", 16'(n_on), 16'd4);
    chk("s3_pwm_off", 16'(n_off), 16'd12);
`else
    n_off = 0;
`endif

    // 4: restart at cycle 40 with 0x01
    cell_in = 8'h17;
    tick(1);
    chk("s4_first_shown", 16'(cell_shown), 16'h17);
    tick(39);
    chk("s4_c39_drive", 16'(dot_drive), 16'h01);
    cell_in = 8'h01;
    tick(1);
    chk("s4_r0_shown", 16'(cell_shown), 16'h01);
    chk("s4_r0_busy", 16'(busy), 16'h1);
    chk("s4_r0_drive", 16'(dot_drive), 16'h00);
    tick(16);
    chk("s4_r16_drive", 16'(dot_drive), 16'h01);
    tick(32);
    chk("s4_r48_skip", 16'(dot_drive), 16'h01);
    tick(6);
    chk("s4_r54_done", 16'(update_done), 16'h0);
    tick(1);
    chk("s4_r55_done", 16'(update_done), 16'h1);
    chk("s4_r55_shown", 16'(cell_shown), 16'h01);

    // 5: enable dropped mid-pulse, then re-enabled
    cell_in = 8'h17;
    tick(1);
    tick(20);
    chk("s5_pulse_drive", 16'(dot_drive), 16'h01);
    enable = 1'b0;
    tick(1);
    chk("s5_off_drive", 16'(dot_drive), 16'h00);
    chk("s5_off_busy", 16'(busy), 16'h0);
    chk("s5_off_shown", 16'(cell_shown), 16'h00);
    tick(3);
    chk("s5_off_stay", 16'({busy, cell_shown}), 16'h000);
    cell_in = 8'h01;
    enable  = 1'b1;
    tick(1);
    chk("s5_re_busy", 16'(busy), 16'h1);
    chk("s5_re_shown", 16'(cell_shown), 16'h01);
    wait_ud(400, lat);
    chk("s5_latency", 16'(lat), 16'd55);
    chk("s5_hold_drive", 16'(dot_drive), 16'h01);

    // 6: async reset mid-pulse, then refresh of 0x3C
    cell_in = 8'h17;
    tick(1);
    tick(30);
    chk("s6_pulse_drive", 16'(dot_drive), 16'h01);
    #1 reset = 1'b1;
    #1;
    chk("s6_async_drive", 16'(dot_drive), 16'h00);
    chk("s6_async_shown", 16'(cell_shown), 16'h00);
    chk("s6_async_busy", 16'({busy, update_done}), 16'h0);
    cell_in = 8'h3C;
    #2 reset = 1'b0;
    tick(1);
    chk("s6_cap_shown", 16'(cell_shown), 16'h3C);
    chk("s6_cap_busy", 16'(busy), 16'h1);
    wait_ud(400, lat);
    chk("s6_latency", 16'(lat), 16'd148);
    chk("s6_hold_drive", 16'(dot_drive), 16'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
